ahb_decoder_rdmux: RTL

AHB address decoder and slave-to-master response multiplexer for the LCD subsystem bus. It decodes the arbitrated address-phase HADDR/HTRANS into one-hot slave selects. It registers the selected slave into the data phase and routes that slave's HRDATA/HREADYOUT/HRESP back to all masters. An internal default slave returns a two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.

---
 rtl/ahb_decoder_rdmux.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_decoder_rdmux.sv
// rtl/ahb_decoder_rdmux.sv - AHB address decoder, data-phase response multiplexer and default error slave
//
// Decodes the address-phase HADDR[31:24] into one-hot slave selects. Registers the
// selected slave into the data phase and routes that slave's read data, ready and
// response back to the masters. Unmapped NONSEQ/SEQ transfers are answered by an
// internal default slave with the two-cycle AHB ERROR response.
//
// Ports:
//   CLK                      bus clock, all state on the rising edge
//   RESET                    asynchronous, active-high reset
//   HADDR[31:0], HTRANS[1:0] address-phase address and transfer type
//   HSEL0..HSEL3             address-phase slave selects (one-hot or all zero)
//   HRDATA0..3, HREADYOUT0..3, HRESP0..3   per-slave data-phase responses
//   HRDATA, HREADY, HRESP    multiplexed data-phase response to the masters
module ahb_decoder_rdmux #(
    parameter logic [7:0] S0_PREFIX = 8'h00,
    parameter logic [7:0] S1_PREFIX = 8'h20,
    parameter logic [7:0] S2_PREFIX = 8'h40,
    parameter logic [7:0] S3_PREFIX = 8'h60
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL0,
    output logic        HSEL1,
    output logic        HSEL2,
    output logic        HSEL3,
    input  logic [31:0] HRDATA0,
    input  logic [31:0] HRDATA1,
    input  logic [31:0] HRDATA2,
    input  logic [31:0] HRDATA3,
    input  logic        HREADYOUT0,
    input  logic        HREADYOUT1,
    input  logic        HREADYOUT2,
    input  logic        HREADYOUT3,
    input  logic [1:0]  HRESP0,
    input  logic [1:0]  HRESP1,
    input  logic [1:0]  HRESP2,
    input  logic [1:0]  HRESP3,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    localparam logic [2:0] SEL_DEF    = 3'd4;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    logic [7:0] prefix;
    logic [2:0] dec_sel;
    logic       dec_default;
    logic       def_accept;
    logic [2:0] sel_q;
    ds_state_t  ds_state;
    logic       def_ready;
    logic [1:0] def_resp;

    // Only the top address byte and HTRANS[1] take part in decoding.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HADDR[23:0], HTRANS[0]};

    assign prefix = HADDR[31:24];

    // Priority decode: the lowest matching slave index wins when prefixes overlap.
    always_comb begin
        dec_sel = SEL_DEF;
        if (prefix == S0_PREFIX) begin
            dec_sel = 3'd0;
        end else if (prefix == S1_PREFIX) begin
            dec_sel = 3'd1;
        end else if (prefix == S2_PREFIX) begin
            dec_sel = 3'd2;
        end else if (prefix == S3_PREFIX) begin
            dec_sel = 3'd3;
        end
    end

    // Selects ignore HTRANS; slaves qualify the transfer type themselves.
    assign HSEL0 = (dec_sel == 3'd0);
    assign HSEL1 = (dec_sel == 3'd1);
    assign HSEL2 = (dec_sel == 3'd2);
    assign HSEL3 = (dec_sel == 3'd3);

    assign dec_default = (dec_sel == SEL_DEF);

    // An active (NONSEQ/SEQ) unmapped transfer is accepted only on a completing cycle.
    assign def_accept = HREADY && dec_default && HTRANS[1];

    // Data-phase select follows the address phase only when the bus is ready.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_q <= SEL_DEF;
        end else if (HREADY) begin
            sel_q <= dec_sel;
        end
    end

    // Default slave: ERROR with wait state, then ERROR with ready. A new unmapped
    // transfer accepted on the second cycle restarts the sequence immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ds_state  <= DS_IDLE;
            def_ready <= 1'b1;
            def_resp  <= RESP_OKAY;
        end else begin
            case (ds_state)
                DS_IDLE: begin
                    if (def_accept) begin
                        ds_state  <= DS_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= RESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    ds_state  <= DS_ERR2;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_ERROR;
                end
                DS_ERR2: begin
                    if (def_accept) begin
                        ds_state  <= DS_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= RESP_ERROR;
                    end else begin
                        ds_state  <= DS_IDLE;
                        def_ready <= 1'b1;
                        def_resp  <= RESP_OKAY;
                    end
                end
                default: begin
                    ds_state  <= DS_IDLE;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_OKAY;
                end
            endcase
        end
    end

    // Return path is purely combinational from the data-phase select.
    always_comb begin
        HRDATA = 32'h0;
        HREADY = def_ready;
        HRESP  = def_resp;
        case (sel_q)
            3'd0: begin
                HRDATA = HRDATA0;
                HREADY = HREADYOUT0;
                HRESP  = HRESP0;
            end
            3'd1: begin
                HRDATA = HRDATA1;
                HREADY = HREADYOUT1;
                HRESP  = HRESP1;
            end
            3'd2: begin
                HRDATA = HRDATA2;
                HREADY = HREADYOUT2;
                HRESP  = HRESP2;
            end
            3'd3: begin
                HRDATA = HRDATA3;
                HREADY = HREADYOUT3;
                HRESP  = HRESP3;
            end
            default: begin
                HRDATA = 32'h0;
                HREADY = def_ready;
                HRESP  = def_resp;
            end
        endcase
    end

endmodule
